// File: rtl/frogger_kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frogger_kbd_pkg
// Description : Shared definitions for the keyboard move scheduler slice.
//               It holds the direction encodings, the PS/2 prefix bytes,
//               the eight arrow/WASD-style scan codes, the parser state
//               enum and a scan-code decode helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package frogger_kbd_pkg;

    // Direction encoding; the value is also the bit index into held/pend
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // PS/2 prefix bytes
    localparam logic [7:0] E0 = 8'hE0;
    localparam logic [7:0] F0 = 8'hF0;

    // Plain make codes
    localparam logic [7:0] SC_UP        = 8'h1D;
    localparam logic [7:0] SC_LEFT      = 8'h1C;
    localparam logic [7:0] SC_DOWN      = 8'h1B;
    localparam logic [7:0] SC_RIGHT     = 8'h23;
    // Extended (E0-prefixed) arrow codes
    localparam logic [7:0] SC_EXT_UP    = 8'h75;
    localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;
    localparam logic [7:0] SC_EXT_DOWN  = 8'h72;
    localparam logic [7:0] SC_EXT_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parser_state_t;

    // Returns {hit, dir}. The extended table is only consulted after E0,
    // so keypad arrows (same codes, no prefix) decode as misses.
    function automatic logic [2:0] decode_scan(input logic [7:0] code,
                                               input logic       ext);
        logic [2:0] res;
        res = 3'b000;
        if (ext) begin
            case (code)
                SC_EXT_UP:    res = {1'b1, DIR_UP};
                SC_EXT_LEFT:  res = {1'b1, DIR_LEFT};
                SC_EXT_DOWN:  res = {1'b1, DIR_DOWN};
                SC_EXT_RIGHT: res = {1'b1, DIR_RIGHT};
                default:      res = 3'b000;
            endcase
        end else begin
            case (code)
                SC_UP:    res = {1'b1, DIR_UP};
                SC_LEFT:  res = {1'b1, DIR_LEFT};
                SC_DOWN:  res = {1'b1, DIR_DOWN};
                SC_RIGHT: res = {1'b1, DIR_RIGHT};
                default:  res = 3'b000;
            endcase
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_move_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : key_move_scheduler_if
// Description : Byte input from the PS/2 receiver and move handshake toward
//               the frog position logic.
//   rx_done_tick / rx_data : received byte strobe and data
//   move_valid / move_ready / move_dir : move handshake
//   held                   : per-direction held state
// Modports    : slave  - the scheduler
//               master - the environment (receiver + game logic)
// Revision    : 1.0 - initial release
// ============================================================================
interface key_move_scheduler_if;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       move_ready;
    logic       move_valid;
    logic [1:0] move_dir;
    logic [3:0] held;

    modport slave (
        input  rx_done_tick, rx_data, move_ready,
        output move_valid, move_dir, held
    );

    modport master (
        output rx_done_tick, rx_data, move_ready,
        input  move_valid, move_dir, held
    );
endinterface
`default_nettype wire

// File: rtl/ps2_code_parser.sv
`default_nettype none
// ============================================================================
// Module      : ps2_code_parser
// Description : Prefix FSM (E0 extended, F0 break) and scan-code decode.
//               Emits a single-cycle event in the same cycle as the final
//               byte of a recognised sequence.
// Ports       : clk, reset (async, active low)
//               rx_done_tick, rx_data         : byte input
//               evt_valid, evt_make, evt_dir  : decoded key event
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_code_parser
    import frogger_kbd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       evt_valid,
    output logic       evt_make,
    output logic [1:0] evt_dir
);

    parser_state_t r_state;
    parser_state_t w_state_next;
    logic          w_ext;
    logic [2:0]    w_dec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_ext = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
    assign w_dec = decode_scan(rx_data, w_ext);

    always_comb begin
        w_state_next = r_state;
        evt_valid    = 1'b0;
        evt_make     = 1'b0;
        evt_dir      = w_dec[1:0];
        if (rx_done_tick) begin
            case (r_state)
                ST_IDLE, ST_EXT: begin
                    if (rx_data == E0) begin
                        w_state_next = ST_EXT;
                    end else if (rx_data == F0) begin
                        w_state_next = (r_state == ST_EXT) ? ST_EXT_BRK : ST_BRK;
                    end else begin
                        evt_valid    = w_dec[2];
                        evt_make     = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    // An E0 here is simply an unmapped break code
                    if (rx_data == F0) begin
                        w_state_next = ST_BRK;
                    end else begin
                        evt_valid    = w_dec[2];
                        w_state_next = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if (rx_data == E0) begin
                        w_state_next = ST_EXT;
                    end else if (rx_data == F0) begin
                        w_state_next = ST_EXT_BRK;
                    end else begin
                        evt_valid    = w_dec[2];
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : key_move_scheduler
// Description : Converts PS/2 bytes into frog moves. Tracks held directions,
//               queues at most one pending move per direction and offers
//               them round-robin over a valid/ready handshake.
//               Optional auto-repeat while keys are held: KEY_AUTOREPEAT_EN.
// Parameters  : REPEAT_CYCLES - cycles between auto-repeat moves (>= 2)
// Ports       : clk, reset (async, active low)
//               kbd (key_move_scheduler_if.slave): rx byte in, move out, held
// Revision    : 1.0 - initial release
// ============================================================================
module key_move_scheduler
    import frogger_kbd_pkg::*;
#(
    parameter int REPEAT_CYCLES = 25_000_000
)
(
    input  logic                  clk,
    input  logic                  reset,
    key_move_scheduler_if.slave   kbd
);

    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be at least 2");
    end

    logic       w_evt_valid;
    logic       w_evt_make;
    logic [1:0] w_evt_dir;

    ps2_code_parser u_parser (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (kbd.rx_done_tick),
        .rx_data      (kbd.rx_data),
        .evt_valid    (w_evt_valid),
        .evt_make     (w_evt_make),
        .evt_dir      (w_evt_dir)
    );

    logic [3:0] r_held;
    logic [3:0] r_pend;
    logic [1:0] r_rr;

    logic       w_make_acc;
    logic [3:0] w_make_set;
    logic [3:0] w_brk_clr;
    logic [3:0] w_xfer_clr;
    logic [3:0] w_repeat_set;
    logic       w_valid;
    logic       w_xfer;
    logic [1:0] w_dir;
    logic [1:0] w_idx;
    logic       w_found;

    // Typematic re-sends of an already held key are ignored
    assign w_make_acc = w_evt_valid & w_evt_make & ~r_held[w_evt_dir];
    assign w_make_set = w_make_acc ? (4'b0001 << w_evt_dir) : 4'b0000;
    assign w_brk_clr  = (w_evt_valid & ~w_evt_make) ? (4'b0001 << w_evt_dir) : 4'b0000;

    // Round-robin pick: first pending bit at or above r_rr, wrapping
    always_comb begin
        w_dir   = 2'd0;
        w_idx   = 2'd0;
        w_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_rr + 2'(i);
            if (!w_found && r_pend[w_idx]) begin
                w_dir   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_valid    = |r_pend;
    assign w_xfer     = w_valid & kbd.move_ready;
    assign w_xfer_clr = w_xfer ? (4'b0001 << w_dir) : 4'b0000;

`ifdef KEY_AUTOREPEAT_EN
    localparam int C_CNT_W = $clog2(REPEAT_CYCLES);

    logic [C_CNT_W-1:0] r_rep_cnt;
    logic               w_rep_wrap;

    assign w_rep_wrap   = (r_held != 4'b0000) &&
                          (r_rep_cnt == C_CNT_W'(REPEAT_CYCLES - 1));
    assign w_repeat_set = w_rep_wrap ? r_held : 4'b0000;

    // A fresh make restarts the interval so the first repeat is a full
    // period after the initial move.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rep_cnt <= '0;
        end else if ((r_held == 4'b0000) || w_make_acc || w_rep_wrap) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end
`else
    assign w_repeat_set = 4'b0000;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_held <= 4'b0000;
            r_pend <= 4'b0000;
            r_rr   <= 2'd0;
        end else begin
            r_held <= (r_held | w_make_set) & ~w_brk_clr;
            // Sets are applied after the transfer clear so a same-cycle
            // request keeps the bit pending.
            r_pend <= (r_pend & ~w_xfer_clr) | w_repeat_set | w_make_set;
            if (w_xfer) begin
                r_rr <= w_dir + 2'd1;
            end
        end
    end

    assign kbd.move_valid = w_valid;
    assign kbd.move_dir   = w_dir;
    assign kbd.held       = r_held;

endmodule
`default_nettype wire

// File: tb/tb_key_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_move_scheduler
// Description : Self-checking bench for key_move_scheduler. A table of
//               byte/ready vectors with hand-computed held/valid/dir, then
//               hand-written sequences for mid-prefix reset and (with
//               KEY_AUTOREPEAT_EN) auto-repeat spacing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_move_scheduler;

    localparam int REPEAT_CYCLES = 8;

    logic clk;
    logic reset;

    key_move_scheduler_if kbd();

    key_move_scheduler #(.REPEAT_CYCLES(REPEAT_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .kbd   (kbd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       tick;
        logic [7:0] data;
        logic       ready;
        logic [3:0] held;
        logic       valid;
        logic [1:0] dir;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic tick, input logic [7:0] data,
                                input logic ready, input logic [3:0] held,
                                input logic valid, input logic [1:0] dir);
        vec_t v;
        v.tick = tick; v.data = data; v.ready = ready;
        v.held = held; v.valid = valid; v.dir = dir;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [3:0] h,
                              input logic v, input logic [1:0] d);
        check({name, " held"},  32'(kbd.held),       32'(h));
        check({name, " valid"}, 32'(kbd.move_valid), 32'(v));
        check({name, " dir"},   32'(kbd.move_dir),   32'(d));
    endtask

    task automatic send_byte(input logic [7:0] b);
        kbd.rx_done_tick = 1'b1;
        kbd.rx_data      = b;
        @(posedge clk);
        #1;
        kbd.rx_done_tick = 1'b0;
        kbd.rx_data      = 8'h00;
    endtask

    task automatic pulse_ready();
        kbd.move_ready = 1'b1;
        @(posedge clk);
        #1;
        kbd.move_ready = 1'b0;
    endtask

    // Hard stop in case the stimulus ever stalls
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int moves;
        int first_at;
        int last_at;
        int gap_bad;

        kbd.rx_done_tick = 1'b0;
        kbd.rx_data      = 8'h00;
        kbd.move_ready   = 1'b0;
        reset            = 1'b0;

        // held, valid, dir after the edge
        // Make then break with no consumer: pend survives the break
        vecs.push_back(mk(1, 8'h1D, 0, 4'b0001, 1, 2'd0));
        vecs.push_back(mk(1, 8'hF0, 0, 4'b0001, 1, 2'd0));
        vecs.push_back(mk(1, 8'h1D, 0, 4'b0000, 1, 2'd0));
        vecs.push_back(mk(0, 8'h00, 1, 4'b0000, 0, 2'd0));      // rr=1
        // Extended right, keypad code ignored, extended break
        vecs.push_back(mk(1, 8'hE0, 0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(1, 8'h74, 0, 4'b1000, 1, 2'd3));
        vecs.push_back(mk(1, 8'h74, 0, 4'b1000, 1, 2'd3));
        vecs.push_back(mk(1, 8'hE0, 0, 4'b1000, 1, 2'd3));
        vecs.push_back(mk(1, 8'hF0, 0, 4'b1000, 1, 2'd3));
        vecs.push_back(mk(1, 8'h74, 0, 4'b0000, 1, 2'd3));
        vecs.push_back(mk(0, 8'h00, 1, 4'b0000, 0, 2'd0));      // rr=0
        // Three makes queued, drained back-to-back
        vecs.push_back(mk(1, 8'h1C, 0, 4'b0010, 1, 2'd1));
        vecs.push_back(mk(1, 8'h1B, 0, 4'b0110, 1, 2'd1));
        vecs.push_back(mk(1, 8'h23, 0, 4'b1110, 1, 2'd1));
        vecs.push_back(mk(0, 8'h00, 1, 4'b1110, 1, 2'd2));      // rr=2
        vecs.push_back(mk(0, 8'h00, 1, 4'b1110, 1, 2'd3));      // rr=3
        vecs.push_back(mk(0, 8'h00, 1, 4'b1110, 0, 2'd0));      // rr=0
        vecs.push_back(mk(1, 8'hF0, 0, 4'b1110, 0, 2'd0));
        vecs.push_back(mk(1, 8'h1C, 0, 4'b1100, 0, 2'd0));
        vecs.push_back(mk(1, 8'hF0, 0, 4'b1100, 0, 2'd0));
        vecs.push_back(mk(1, 8'h1B, 0, 4'b1000, 0, 2'd0));
        vecs.push_back(mk(1, 8'hF0, 0, 4'b1000, 0, 2'd0));
        vecs.push_back(mk(1, 8'h23, 0, 4'b0000, 0, 2'd0));
        // rr back at 0: left wins over right
        vecs.push_back(mk(1, 8'h23, 0, 4'b1000, 1, 2'd3));
        vecs.push_back(mk(1, 8'h1C, 0, 4'b1010, 1, 2'd1));
        vecs.push_back(mk(0, 8'h00, 1, 4'b1010, 1, 2'd3));
        vecs.push_back(mk(0, 8'h00, 1, 4'b1010, 0, 2'd0));
        vecs.push_back(mk(1, 8'hF0, 0, 4'b1010, 0, 2'd0));
        vecs.push_back(mk(1, 8'h23, 0, 4'b0010, 0, 2'd0));
        vecs.push_back(mk(1, 8'hF0, 0, 4'b0010, 0, 2'd0));
        vecs.push_back(mk(1, 8'h1C, 0, 4'b0000, 0, 2'd0));
        // Typematic repeats merge into one move
        vecs.push_back(mk(1, 8'h1D, 0, 4'b0001, 1, 2'd0));
        vecs.push_back(mk(1, 8'h1D, 0, 4'b0001, 1, 2'd0));
        vecs.push_back(mk(1, 8'h1D, 0, 4'b0001, 1, 2'd0));
        vecs.push_back(mk(1, 8'h1D, 0, 4'b0001, 1, 2'd0));
        vecs.push_back(mk(0, 8'h00, 1, 4'b0001, 0, 2'd0));
        vecs.push_back(mk(0, 8'h00, 1, 4'b0001, 0, 2'd0));
        vecs.push_back(mk(1, 8'hF0, 0, 4'b0001, 0, 2'd0));
        vecs.push_back(mk(1, 8'h1D, 0, 4'b0000, 0, 2'd0));
        // Unmapped, keypad arrow, plain code after E0
        vecs.push_back(mk(1, 8'h15, 0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(1, 8'h75, 0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(1, 8'hE0, 0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(1, 8'h1D, 0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(1, 8'h1D, 0, 4'b0001, 1, 2'd0));
        // Transfer and new make on the same bit: set wins
        vecs.push_back(mk(1, 8'hF0, 0, 4'b0001, 1, 2'd0));
        vecs.push_back(mk(1, 8'h1D, 0, 4'b0000, 1, 2'd0));
        vecs.push_back(mk(1, 8'h1D, 1, 4'b0001, 1, 2'd0));
        vecs.push_back(mk(0, 8'h00, 1, 4'b0001, 0, 2'd0));
        vecs.push_back(mk(1, 8'hF0, 0, 4'b0001, 0, 2'd0));
        vecs.push_back(mk(1, 8'h1D, 0, 4'b0000, 0, 2'd0));
        // Break of a key not held; repeated prefixes
        vecs.push_back(mk(1, 8'hF0, 0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(1, 8'h1B, 0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(1, 8'hE0, 0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(1, 8'hE0, 0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(1, 8'h6B, 0, 4'b0010, 1, 2'd1));
        vecs.push_back(mk(0, 8'h00, 1, 4'b0010, 0, 2'd0));
        vecs.push_back(mk(1, 8'hE0, 0, 4'b0010, 0, 2'd0));
        vecs.push_back(mk(1, 8'hF0, 0, 4'b0010, 0, 2'd0));
        vecs.push_back(mk(1, 8'hE0, 0, 4'b0010, 0, 2'd0));
        vecs.push_back(mk(1, 8'hF0, 0, 4'b0010, 0, 2'd0));
        vecs.push_back(mk(1, 8'h6B, 0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(1, 8'hF0, 0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(1, 8'hF0, 0, 4'b0000, 0, 2'd0));
        vecs.push_back(mk(1, 8'h1C, 0, 4'b0000, 0, 2'd0));

        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 4'b0000, 1'b0, 2'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outs("post_reset", 4'b0000, 1'b0, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            kbd.rx_done_tick = vecs[i].tick;
            kbd.rx_data      = vecs[i].data;
            kbd.move_ready   = vecs[i].ready;
            @(posedge clk);
            #1;
            kbd.rx_done_tick = 1'b0;
            kbd.rx_data      = 8'h00;
            kbd.move_ready   = 1'b0;
            check_outs($sformatf("vec%0d", i), vecs[i].held, vecs[i].valid,
                       vecs[i].dir);
        end

        // Reset in the middle of E0 F0 with a move pending
        send_byte(8'h23);
        check_outs("rst_pre", 4'b1000, 1'b1, 2'd3);
        send_byte(8'hE0);
        send_byte(8'hF0);
        #2;
        reset = 1'b0;
        #1;
        check_outs("rst_async", 4'b0000, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_byte(8'h1D);
        check_outs("rst_then_make", 4'b0001, 1'b1, 2'd0);
        pulse_ready();
        check_outs("rst_drain", 4'b0001, 1'b0, 2'd0);
        send_byte(8'hF0);
        send_byte(8'h1D);
        check_outs("rst_release", 4'b0000, 1'b0, 2'd0);

`ifdef KEY_AUTOREPEAT_EN
        // Hold right with a permanently ready consumer
        moves    = 0;
        first_at = -1;
        last_at  = -1;
        gap_bad  = 0;
        kbd.move_ready = 1'b1;
        send_byte(8'h23);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (kbd.move_valid) begin
                if (kbd.move_dir != 2'd3) gap_bad++;
                if (last_at >= 0 && (c - last_at) != REPEAT_CYCLES) gap_bad++;
                if (first_at < 0) first_at = c;
                last_at = c;
                moves++;
            end
        end
        check("rep_moves", 32'(moves), 32'd4);
        check("rep_first", 32'(first_at), 32'd1);
        check("rep_spacing", 32'(gap_bad), 32'd0);
        @(posedge clk);
        #1;
        send_byte(8'hF0);
        send_byte(8'h23);
        repeat (2) @(posedge clk);
        moves = 0;
        for (int c = 0; c < 3 * REPEAT_CYCLES; c++) begin
            @(negedge clk);
            if (kbd.move_valid) moves++;
        end
        check("rep_after_break", 32'(moves), 32'd0);
        #1;
        check("rep_held_clear", 32'(kbd.held), 32'd0);
        kbd.move_ready = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
